nibble_mux_serializer: RTL

- Upstream sequencer for the 4:1 bit-select mux in the datapath. Accepts 4-bit words over a valid/ready handshake and buffers one word ahead of the word in flight.
- Drives the mux's d and select inputs and steps select through the four bit positions on successive cycles.
- Forwards the mux's q output as a serial bit stream with its own valid/ready handshake and a last-bit marker.

---
 rtl/nibble_mux_serializer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/nibble_mux_serializer.sv
// Feeds a 4:1 bit-select mux one word at a time and streams its q output as
// serial bits. Holds one word pending behind the word currently being shifted.
//   state | meaning
//   IDLE  | no word active; loads the pending word when one is present
//   SHIFT | bit of the active word offered on ser_bit/ser_valid
//   GAP   | idle spacing after a word's last bit
module nibble_mux_serializer #(
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    output logic [3:0]       mux_d,
    output logic [1:0]       mux_select,
    input  logic             mux_q,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [1:0] FIRST_SEL = MSB_FIRST ? 2'd3 : 2'd0;
    localparam logic [3:0] GAP_LOAD  = (GAP_CYCLES != 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam bit         HAS_GAP   = (GAP_CYCLES != 0);

    state_t     state;
    logic       pend_valid;
    logic [3:0] pend_data;
    logic [1:0] bit_idx;
    logic [3:0] gap_cnt;
    logic       accept;
    logic       xfer;
    logic       word_done;
    logic       load_now;

    assign in_ready  = !pend_valid;
    assign accept    = in_valid && in_ready;
    assign ser_valid = (state == SHIFT);
    assign ser_bit   = mux_q;
    assign ser_last  = ser_valid && (bit_idx == 2'd3);
    assign xfer      = ser_valid && ser_ready;
    assign word_done = xfer && (bit_idx == 2'd3);

    // Every path that brings a new word into the mux register funnels through here.
    always_comb begin
        load_now = 1'b0;
        if (pend_valid) begin
            case (state)
                IDLE:    load_now = 1'b1;
                SHIFT:   load_now = word_done && !HAS_GAP;
                GAP:     load_now = (gap_cnt == 4'd0);
                default: load_now = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            pend_data  <= 4'd0;
            mux_d      <= 4'd0;
            mux_select <= FIRST_SEL;
            bit_idx    <= 2'd0;
            gap_cnt    <= 4'd0;
            word_count <= '0;
        end else begin
            if (load_now) begin
                pend_valid <= 1'b0;
            end else if (accept) begin
                pend_valid <= 1'b1;
                pend_data  <= in_data;
            end

            if (word_done) begin
                word_count <= word_count + CNT_W'(1);
            end

            if (load_now) begin
                mux_d      <= pend_data;
                mux_select <= FIRST_SEL;
                bit_idx    <= 2'd0;
                state      <= SHIFT;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    SHIFT: begin
                        if (xfer && (bit_idx != 2'd3)) begin
                            bit_idx    <= bit_idx + 2'd1;
                            mux_select <= MSB_FIRST ? (mux_select - 2'd1) : (mux_select + 2'd1);
                        end else if (word_done) begin
                            if (HAS_GAP) begin
                                gap_cnt <= GAP_LOAD;
                                state   <= GAP;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == 4'd0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
